rv_id_decode: RTL and testbench



---
 rtl/rv_id_decode_if.sv | 39 +++
 rtl/rv_id_decode.sv | 170 +++++++++++++++++
 tb/tb_rv_id_decode.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_id_decode_if.sv
// rv_id_decode_if
//   Bundles the signals between the IF/ID register / hazard unit and the
//   ID-stage decode register.
//   master : drives instr, en, bubble; observes the registered decode result
//   slave  : the decode block; consumes instr, en, bubble; drives results
//   Signals:
//     instr      32  instruction from the IF/ID register
//     en          1  1 = load a new decode result, 0 = hold
//     bubble      1  1 = zero all control outputs (hazard mux)
//     alu_src, mem_to_reg, mem_read, mem_write, branch, reg_write  1 each
//     alu_op      2  registered ALUOp
//     alu_ctrl    4  registered ALU operation code
//     imm        32  registered sign-extended immediate
interface rv_id_decode_if;
  logic        [31:0] instr;
  logic               en;
  logic               bubble;
  logic               alu_src;
  logic               mem_to_reg;
  logic               mem_read;
  logic               mem_write;
  logic               branch;
  logic               reg_write;
  logic         [1:0] alu_op;
  logic         [3:0] alu_ctrl;
  logic signed [31:0] imm;

  modport master (
    output instr, en, bubble,
    input  alu_src, mem_to_reg, mem_read, mem_write, branch, reg_write,
    input  alu_op, alu_ctrl, imm
  );

  modport slave (
    input  instr, en, bubble,
    output alu_src, mem_to_reg, mem_read, mem_write, branch, reg_write,
    output alu_op, alu_ctrl, imm
  );
endinterface

// File: rtl/rv_id_decode.sv
// rv_id_decode
//   ID-stage decode for a 5-stage RV32I pipeline. Combines main control,
//   immediate generation and ALU-operation decode of the IF/ID instruction
//   and registers the result into the ID output register feeding ID/EX.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   synchronous, active-high reset
//     dec    slave modport of rv_id_decode_if (instr/en/bubble in,
//            registered control, alu_op, alu_ctrl and imm out)
//   Edge priority: reset > hold (en=0) > bubble > normal load.
//   A bubble clears the control fields but still loads the immediate.
module rv_id_decode (
  input  logic           clk,
  input  logic           reset,
  rv_id_decode_if.slave  dec
);

  // Opcodes
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // Control bundle ordering: {alu_src, mem_to_reg, mem_read, mem_write,
  // branch, reg_write}
  typedef logic [5:0] ctrl_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic [1:0] alu_op;
  } main_t;

  function automatic main_t main_decode(input logic [6:0] opc);
    main_t m;
    m = '{ctrl: 6'b000000, alu_op: ALUOP_ADD};
    case (opc)
      OPC_RTYPE:  m = '{ctrl: 6'b000001, alu_op: ALUOP_R};
      OPC_LOAD:   m = '{ctrl: 6'b111001, alu_op: ALUOP_ADD};
      OPC_STORE:  m = '{ctrl: 6'b100100, alu_op: ALUOP_ADD};
      OPC_BRANCH: m = '{ctrl: 6'b000010, alu_op: ALUOP_SUB};
      OPC_OPIMM:  m = '{ctrl: 6'b100001, alu_op: ALUOP_I};
      default:    m = '{ctrl: 6'b000000, alu_op: ALUOP_ADD};
    endcase
    return m;
  endfunction

  // funct3 map shared by R-type and OP-IMM. f7_sub selects SUB for 000 and
  // is only honoured for R-type; f7_sra selects SRA for 101 in both forms.
  function automatic logic [3:0] funct3_op(input logic [2:0] f3,
                                           input logic       f7_sub,
                                           input logic       f7_sra);
    logic [3:0] op;
    case (f3)
      3'b000:  op = f7_sub ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7_sra ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [3:0] alu_decode(input logic [1:0] alu_op,
                                            input logic [2:0] f3,
                                            input logic       f7);
    logic [3:0] op;
    case (alu_op)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_R:   op = funct3_op(f3, f7, f7);
      default:   op = funct3_op(f3, 1'b0, f7);   // addi never subtracts
    endcase
    return op;
  endfunction

  // B and J immediates are halfword offsets; the branch-target shifter
  // downstream supplies the <<1, so no zero LSB is appended here.
  function automatic logic signed [31:0] imm_decode(input logic [31:0] ins);
    logic signed [31:0] im;
    case (ins[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR:
        im = {{20{ins[31]}}, ins[31:20]};
      OPC_STORE:
        im = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OPC_BRANCH:
        im = {{20{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8]};
      OPC_LUI, OPC_AUIPC:
        im = {ins[31:12], 12'b0};
      OPC_JAL:
        im = {{12{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21]};
      default:
        im = '0;
    endcase
    return im;
  endfunction

  // ---- p0: combinational decode of the IF/ID instruction ----
  main_t              main_p0;
  logic         [3:0] alu_ctrl_p0;
  logic signed [31:0] imm_p0;

  always_comb begin
    main_p0     = main_decode(dec.instr[6:0]);
    alu_ctrl_p0 = alu_decode(main_p0.alu_op, dec.instr[14:12], dec.instr[30]);
    imm_p0      = imm_decode(dec.instr);
  end

  // ---- p1: ID output register ----
  ctrl_t              ctrl_p1;
  logic         [1:0] alu_op_p1;
  logic         [3:0] alu_ctrl_p1;
  logic signed [31:0] imm_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_p1     <= '0;
      alu_op_p1   <= ALUOP_ADD;
      alu_ctrl_p1 <= ALU_ADD;
      imm_p1      <= '0;
    end else if (dec.en) begin
      if (dec.bubble) begin
        ctrl_p1     <= '0;
        alu_op_p1   <= ALUOP_ADD;
        alu_ctrl_p1 <= ALU_ADD;
      end else begin
        ctrl_p1     <= main_p0.ctrl;
        alu_op_p1   <= main_p0.alu_op;
        alu_ctrl_p1 <= alu_ctrl_p0;
      end
      imm_p1 <= imm_p0;
    end
  end

  assign dec.alu_src    = ctrl_p1[5];
  assign dec.mem_to_reg = ctrl_p1[4];
  assign dec.mem_read   = ctrl_p1[3];
  assign dec.mem_write  = ctrl_p1[2];
  assign dec.branch     = ctrl_p1[1];
  assign dec.reg_write  = ctrl_p1[0];
  assign dec.alu_op     = alu_op_p1;
  assign dec.alu_ctrl   = alu_ctrl_p1;
  assign dec.imm        = imm_p1;

endmodule

// File: tb/tb_rv_id_decode.sv
// Testbench for rv_id_decode. Expected results are pushed to a queue when
// stimulus is driven and popped/compared one edge later. Results are packed
// as {alu_src, mem_to_reg, mem_read, mem_write, branch, reg_write,
//     alu_op[1:0], alu_ctrl[3:0], imm[31:0]}.
module tb_rv_id_decode;

  logic clk = 1'b0;
  logic reset;

  rv_id_decode_if dif ();

  rv_id_decode dut (
    .clk   (clk),
    .reset (reset),
    .dec   (dif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic        bub;
    logic [31:0] ins;
    logic [43:0] exp;
  } step_t;

  logic [43:0] exp_q [$];
  int vectors     = 0;
  int miscompares = 0;

  localparam logic [43:0] RST_VAL = {6'b000000, 2'b00, 4'b0010, 32'h0};

  function automatic logic [43:0] pk(input logic [5:0] c, input logic [1:0] op,
                                     input logic [3:0] ac, input logic [31:0] im);
    return {c, op, ac, im};
  endfunction

  function automatic logic [43:0] observe();
    return {dif.alu_src, dif.mem_to_reg, dif.mem_read, dif.mem_write,
            dif.branch, dif.reg_write, dif.alu_op, dif.alu_ctrl, dif.imm};
  endfunction

  // Reference decode, built from the instruction-format definitions: branch
  // and jump offsets are assembled as byte offsets then halved.
  function automatic logic [43:0] ref_decode(input logic [31:0] i);
    logic [5:0]         c;
    logic [1:0]         op;
    logic [3:0]         ac;
    logic [31:0]        im;
    logic signed [12:0] boff;
    logic signed [20:0] joff;
    logic [3:0]         fmap [8];
    fmap = '{4'h2, 4'h4, 4'h7, 4'h8, 4'h3, 4'h5, 4'h1, 4'h0};
    c = 6'b0; op = 2'b00; im = 32'h0;
    boff = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    joff = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    case (i[6:0])
      7'h33: begin c = 6'b000001; op = 2'b10; end
      7'h03: begin c = 6'b111001; im = 32'($signed(i[31:20])); end
      7'h23: begin c = 6'b100100; im = 32'($signed({i[31:25], i[11:7]})); end
      7'h63: begin c = 6'b000010; op = 2'b01; im = 32'(boff >>> 1); end
      7'h13: begin c = 6'b100001; op = 2'b11; im = 32'($signed(i[31:20])); end
      7'h67: im = 32'($signed(i[31:20]));
      7'h37, 7'h17: im = {i[31:12], 12'h000};
      7'h6F: im = 32'(joff >>> 1);
      default: ;
    endcase
    if (op == 2'b00)      ac = 4'h2;
    else if (op == 2'b01) ac = 4'h6;
    else begin
      ac = fmap[i[14:12]];
      if (i[14:12] == 3'b101 && i[30]) ac = 4'h9;
      if (i[14:12] == 3'b000 && i[30] && op == 2'b10) ac = 4'h6;
    end
    return {c, op, ac, im};
  endfunction

  task automatic apply(input logic r, input logic e, input logic b,
                       input logic [31:0] ins, input logic [43:0] expv);
    reset      = r;
    dif.en     = e;
    dif.bubble = b;
    dif.instr  = ins;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t tbl [$];
    logic [43:0] got, want;
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h00A00093, RST_VAL});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h00A00093, RST_VAL});
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].bub, tbl[i].ins, tbl[i].exp);
      got = observe(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset[%0d] got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_addi();
    step_t tbl [$];
    logic [43:0] got, want;
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h00A00093, pk(6'b100001, 2'b11, 4'b0010, 32'h0000000A)});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'hC0000093, pk(6'b100001, 2'b11, 4'b0010, 32'hFFFFFC00)});
    // addi with instr[30] set must still add
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h40000093, pk(6'b100001, 2'b11, 4'b0010, 32'h00000400)});
    // srai x1,x1,3
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h4030D093, pk(6'b100001, 2'b11, 4'b1001, 32'h00000403)});
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].bub, tbl[i].ins, tbl[i].exp);
      got = observe(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL addi[%0d] got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_rtype();
    step_t tbl [$];
    logic [43:0] got, want;
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h402081B3, pk(6'b000001, 2'b10, 4'b0110, 32'h0)});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0020F1B3, pk(6'b000001, 2'b10, 4'b0000, 32'h0)});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h4020D1B3, pk(6'b000001, 2'b10, 4'b1001, 32'h0)});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h002081B3, pk(6'b000001, 2'b10, 4'b0010, 32'h0)});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0020B1B3, pk(6'b000001, 2'b10, 4'b1000, 32'h0)});
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].bub, tbl[i].ins, tbl[i].exp);
      got = observe(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL rtype[%0d] got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_memory_branch();
    step_t tbl [$];
    logic [43:0] got, want;
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'hFFC12283, pk(6'b111001, 2'b00, 4'b0010, 32'hFFFFFFFC)});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h00512423, pk(6'b100100, 2'b00, 4'b0010, 32'h00000008)});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'hFE208CE3, pk(6'b000010, 2'b01, 4'b0110, 32'hFFFFFFFC)});
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].bub, tbl[i].ins, tbl[i].exp);
      got = observe(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL membr[%0d] got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_stall_bubble();
    step_t tbl [$];
    logic [43:0] got, want, lw_v;
    lw_v = pk(6'b111001, 2'b00, 4'b0010, 32'hFFFFFFFC);
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'hFFC12283, lw_v});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h402081B3, lw_v});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h00512423, lw_v});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h402081B3, RST_VAL});
    // bubble still loads the immediate
    tbl.push_back('{1'b0, 1'b1, 1'b1, 32'hFFC12283, pk(6'b0, 2'b00, 4'b0010, 32'hFFFFFFFC)});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0000007F, RST_VAL});
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].bub, tbl[i].ins, tbl[i].exp);
      got = observe(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL stall[%0d] got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_other_formats();
    step_t tbl [$];
    logic [43:0] got, want;
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h12345037, pk(6'b0, 2'b00, 4'b0010, 32'h12345000)});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'hFFFFF097, pk(6'b0, 2'b00, 4'b0010, 32'hFFFFF000)});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0080006F, pk(6'b0, 2'b00, 4'b0010, 32'h00000004)});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'hFFDFF06F, pk(6'b0, 2'b00, 4'b0010, 32'hFFFFFFFE)});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'hFFC080E7, pk(6'b0, 2'b00, 4'b0010, 32'hFFFFFFFC)});
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].bub, tbl[i].ins, tbl[i].exp);
      got = observe(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL format[%0d] got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_priority();
    step_t tbl [$];
    logic [43:0] got, want;
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'hFFC12283, pk(6'b111001, 2'b00, 4'b0010, 32'hFFFFFFFC)});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'hFFC12283, RST_VAL});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'hFE208CE3, pk(6'b000010, 2'b01, 4'b0110, 32'hFFFFFFFC)});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hFFC12283, RST_VAL});
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].bub, tbl[i].ins, tbl[i].exp);
      got = observe(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL rstprio[%0d] got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  opcs [10];
    logic [43:0] state, dv, got, want;
    logic [31:0] ins;
    logic        r, e, b;
    opcs = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h13, 7'h67, 7'h37, 7'h17, 7'h6F, 7'h7F};
    state = RST_VAL;
    apply(1'b1, 1'b1, 1'b0, 32'h0, state);
    got = observe(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL b2b_init got %h want %h", got, want);
    end
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      ins[6:0] = opcs[$urandom_range(0, 9)];
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 3) == 0);
      dv = ref_decode(ins);
      if (r)       state = RST_VAL;
      else if (!e) state = state;
      else if (b)  state = {6'b0, 2'b00, 4'b0010, dv[31:0]};
      else         state = dv;
      apply(r, e, b, ins, state);
      got = observe(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL b2b[%0d] instr %h got %h want %h", n, ins, got, want);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    dif.en     = 1'b0;
    dif.bubble = 1'b0;
    dif.instr  = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_addi();
    test_rtype();
    test_memory_branch();
    test_stall_bubble();
    test_other_formats();
    test_reset_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
